int_arbiter: RTL and testbench

Interrupt controller between the four external interrupt lines (intPort1..intPort4) and the single-cycle CPU's control unit. Synchronises and latches requests, applies a software mask, selects one source by priority, and presents a single request plus one-hot source vector to the control unit. It then runs an acknowledge / end-of-interrupt handshake, so only one interrupt is in service at a time (no nesting).

---
 rtl/int_arbiter.sv | 258 +++++++++++++++++++++++++
 tb/tb_int_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_arbiter.sv
// Purpose    : interrupt arbiter; syncs 4 IRQ lines, latches pending, masks, grants one source to the control unit.
// Latency    : SYNC_STAGES=2, EDGE_MODE=1: int_in high before edge k -> pending after k+2 -> irq/int_vec after k+3.
// Backpressure: irq and int_vec are held until ack; no further grant until eoi closes the service window.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-low reset
//   int_in     raw interrupt lines, bit0 = intPort1 (highest fixed priority) .. bit3 = intPort4
//   cfg_we     mask write strobe; cfg_mask is captured on the next edge
//   cfg_mask   new mask, 1 = source disabled (it still accumulates pending)
//   ack        control unit accepts the presented interrupt (only honoured in REQ)
//   eoi        end of interrupt (only honoured in SERVICE)
//   irq        interrupt request to the control unit
//   int_vec    one-hot granted source, 0 when nothing is granted
//   pending    latched pending bits
//   mask       current mask register
//   in_service high from the accepted ack until eoi
//   eoi_err    sticky flag, eoi seen outside SERVICE; cleared only by reset
//
// Build option: define INT_ROUND_ROBIN_EN for rotating priority (2-bit pointer rr);
// otherwise fixed priority with bit0 highest.

module int_arbiter #(
  parameter int SYNC_STAGES = 2,  // legal 2..3
  parameter int EDGE_MODE   = 1   // 1 = rising-edge pending, 0 = level pending
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] int_in,
  input  logic       cfg_we,
  input  logic [3:0] cfg_mask,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [3:0] int_vec,
  output logic [3:0] pending,
  output logic [3:0] mask,
  output logic       in_service,
  output logic       eoi_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state_q, state_d;

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] s;
  logic [3:0] s_prev_q;

  logic [3:0] pending_q, pending_d;
  logic [3:0] mask_q;
  logic [3:0] int_vec_q, int_vec_d;
  logic       irq_q, irq_d;
  logic       in_service_q, in_service_d;
  logic       eoi_err_q, eoi_err_d;

  logic [3:0] set_vec;
  logic [3:0] clr_vec;
  logic [3:0] eligible;
  logic [3:0] sel_vec;
  logic       ack_take;

  // ------------------------------------------------------------------
  // Input synchroniser and edge detect
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 4'b0000;
      end
      s_prev_q <= 4'b0000;
    end else begin
      sync_q[0] <= int_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      s_prev_q <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    if (EDGE_MODE != 0) begin
      set_vec = s & ~s_prev_q;
    end else begin
      set_vec = s;
    end
  end

  // ------------------------------------------------------------------
  // Pending and mask
  // ------------------------------------------------------------------
  // Only the granted source is cleared, and only by an accepted ack.
  // OR-ing set_vec in last lets a fresh request win over the clear.
  assign clr_vec   = ack_take ? int_vec_q : 4'b0000;
  assign pending_d = (pending_q & ~clr_vec) | set_vec;
  assign eligible  = pending_q & ~mask_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 4'b0000;
      mask_q    <= 4'b0000;
    end else begin
      pending_q <= pending_d;
      if (cfg_we) begin
        mask_q <= cfg_mask;
      end
    end
  end

  // ------------------------------------------------------------------
  // Source selection
  // ------------------------------------------------------------------
`ifdef INT_ROUND_ROBIN_EN
  logic [1:0] rr_q;
  logic [1:0] grant_idx;

  // Index of the (one-hot) granted source.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        idx = i[1:0];
      end
    end
    return idx;
  endfunction

  // First eligible source scanning upward from start, wrapping mod 4.
  function automatic logic [3:0] rr_pick(input logic [3:0] v, input logic [1:0] start);
    logic [3:0] res;
    logic [1:0] idx;
    logic       found;
    res   = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + i[1:0];
      if (!found && v[idx]) begin
        res[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

  assign grant_idx = onehot_idx(int_vec_q);
  assign sel_vec   = rr_pick(eligible, rr_q);

  // Pointer moves past the source that was just accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q <= 2'd0;
    end else if (ack_take) begin
      rr_q <= grant_idx + 2'd1;
    end
  end
`else
  // Fixed priority: lowest set bit wins.
  function automatic logic [3:0] fixed_pick(input logic [3:0] v);
    logic [3:0] res;
    logic       found;
    res   = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && v[i]) begin
        res[i] = 1'b1;
        found  = 1'b1;
      end
    end
    return res;
  endfunction

  assign sel_vec = fixed_pick(eligible);
`endif

  // ------------------------------------------------------------------
  // Handshake FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      int_vec_q    <= 4'b0000;
      irq_q        <= 1'b0;
      in_service_q <= 1'b0;
      eoi_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      int_vec_q    <= int_vec_d;
      irq_q        <= irq_d;
      in_service_q <= in_service_d;
      eoi_err_q    <= eoi_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    int_vec_d    = int_vec_q;
    irq_d        = irq_q;
    in_service_d = in_service_q;
    eoi_err_d    = eoi_err_q;
    ack_take     = 1'b0;

    case (state_q)
      IDLE: begin
        // The grant is latched here, so later mask writes cannot retract it.
        if (eligible != 4'b0000) begin
          int_vec_d = sel_vec;
          irq_d     = 1'b1;
          state_d   = REQ;
        end
        if (eoi) begin
          eoi_err_d = 1'b1;
        end
      end

      REQ: begin
        if (ack) begin
          ack_take     = 1'b1;
          irq_d        = 1'b0;
          in_service_d = 1'b1;
          state_d      = SERVICE;
        end
        if (eoi) begin
          eoi_err_d = 1'b1;
        end
      end

      SERVICE: begin
        if (eoi) begin
          in_service_d = 1'b0;
          int_vec_d    = 4'b0000;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d      = IDLE;
        int_vec_d    = 4'b0000;
        irq_d        = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  assign irq        = irq_q;
  assign int_vec    = int_vec_q;
  assign pending    = pending_q;
  assign mask       = mask_q;
  assign in_service = in_service_q;
  assign eoi_err    = eoi_err_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Purpose    : directed self-checking bench for int_arbiter with a grant scoreboard.
// Latency    : checks pending/irq timing relative to the int_in edge as well as grant order.
// Backpressure: drives ack/eoi pulses itself; every wait for irq is bounded.
module tb_int_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] int_in;
  logic       cfg_we;
  logic [3:0] cfg_mask;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [3:0] int_vec;
  logic [3:0] pending;
  logic [3:0] mask;
  logic       in_service;
  logic       eoi_err;

  int n_tests;
  int n_fail;

  logic [3:0] exp_q[$];

  int_arbiter #(
    .SYNC_STAGES (2),
    .EDGE_MODE   (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .int_in     (int_in),
    .cfg_we     (cfg_we),
    .cfg_mask   (cfg_mask),
    .ack        (ack),
    .eoi        (eoi),
    .irq        (irq),
    .int_vec    (int_vec),
    .pending    (pending),
    .mask       (mask),
    .in_service (in_service),
    .eoi_err    (eoi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_int(input logic [3:0] v);
    int_in = v;
    @(negedge clk);
    int_in = 4'b0000;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
  endtask

  task automatic write_mask(input logic [3:0] m);
    cfg_we   = 1'b1;
    cfg_mask = m;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Wait (bounded) for irq, then compare the presented source with the scoreboard head.
  task automatic wait_grant(input string tag);
    logic [3:0] exp;
    int         cyc;
    cyc = 0;
    while (irq !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_irq"}, irq, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, int_vec, 4'bxxxx);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_vec"}, int_vec, exp);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b0;
    int_in   = 4'b0000;
    cfg_we   = 1'b0;
    cfg_mask = 4'b0000;
    ack      = 1'b0;
    eoi      = 1'b0;

    // Reset state
    tick(3);
    check("rst_irq", irq, 0);
    check("rst_vec", int_vec, 0);
    check("rst_pend", pending, 0);
    check("rst_mask", mask, 0);
    check("rst_insvc", in_service, 0);
    check("rst_eoierr", eoi_err, 0);
    reset = 1'b1;
    tick(2);

    // 1: single source, exact latency and full handshake
    exp_q.push_back(4'b0100);
    pulse_int(4'b0100);                // edge k
    tick(1);                           // after k+1
    check("t1_pend_k1", pending, 4'b0000);
    tick(1);                           // after k+2
    check("t1_pend_k2", pending, 4'b0100);
    check("t1_irq_k2", irq, 0);
    tick(1);                           // after k+3
    check("t1_irq_k3", irq, 1);
    wait_grant("t1");
    do_ack();
    check("t1_pend_ack", pending, 4'b0000);
    check("t1_insvc_ack", in_service, 1);
    check("t1_irq_ack", irq, 0);
    check("t1_vec_svc", int_vec, 4'b0100);
    do_eoi();
    check("t1_vec_eoi", int_vec, 4'b0000);
    check("t1_insvc_eoi", in_service, 0);
    check("t1_eoierr", eoi_err, 0);

    // 2: simultaneous sources, fixed priority order
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    pulse_int(4'b1010);
    wait_grant("t2a");
    check("t2_pend", pending, 4'b1010);
    do_ack();
    check("t2_pend_ack", pending, 4'b1000);
    do_eoi();
    wait_grant("t2b");
    do_ack();
    do_eoi();
    check("t2_pend_end", pending, 4'b0000);

    // 3: masked source accumulates pending without irq
    write_mask(4'b0001);
    check("t3_mask", mask, 4'b0001);
    pulse_int(4'b0001);
    tick(6);
    check("t3_pend", pending, 4'b0001);
    check("t3_irq_masked", irq, 0);
    exp_q.push_back(4'b0001);
    write_mask(4'b0000);
    check("t3_irq_unmask_edge", irq, 0);
    wait_grant("t3");
    do_ack();
    do_eoi();

    // 4: request during SERVICE waits for eoi, then grants one cycle later
    exp_q.push_back(4'b0001);
    pulse_int(4'b0001);
    wait_grant("t4a");
    do_ack();
    pulse_int(4'b0001);
    tick(5);
    check("t4_irq_svc", irq, 0);
    check("t4_pend_svc", pending, 4'b0001);
    exp_q.push_back(4'b0001);
    do_eoi();
    check("t4_irq_idle", irq, 0);
    tick(1);
    check("t4_irq_next", irq, 1);
    wait_grant("t4b");
    do_ack();
    do_eoi();

    // 5: stray eoi/ack in IDLE, then reset in SERVICE
    do_eoi();
    check("t5_eoierr", eoi_err, 1);
    check("t5_irq", irq, 0);
    do_ack();
    check("t5_insvc_stray_ack", in_service, 0);
    write_mask(4'b1000);
    exp_q.push_back(4'b0100);
    pulse_int(4'b0100);
    wait_grant("t5");
    do_ack();
    pulse_int(4'b0010);
    tick(4);
    check("t5_pend_svc", pending, 4'b0010);
    reset = 1'b0;
    #1;
    check("t5_rst_irq", irq, 0);
    check("t5_rst_vec", int_vec, 0);
    check("t5_rst_pend", pending, 0);
    check("t5_rst_mask", mask, 0);
    check("t5_rst_insvc", in_service, 0);
    check("t5_rst_eoierr", eoi_err, 0);
    tick(2);
    reset = 1'b1;
    tick(6);
    check("t5_post_irq", irq, 0);

    // 6: sources 0 and 1 keep re-firing
`ifdef INT_ROUND_ROBIN_EN
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
`else
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0001);
`endif
    pulse_int(4'b0011);
    for (int g = 0; g < 3; g++) begin
      wait_grant($sformatf("t6_g%0d", g));
      do_ack();
      pulse_int(4'b0011);
      tick(4);
      do_eoi();
    end

    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
